// File: rtl/rs_encoder.sv
// Systematic RS(N_DATA+16, N_DATA) encoder over GF(256): forwards data bytes, then appends 16 LFSR parity bytes.
// Optional sync-byte gate on byte 0 is enabled by defining RS_ENC_SYNC_CHECK_EN.
module rs_encoder #(
  parameter int N_DATA = 188
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_parity,
  output logic       sync_err
);

  typedef enum logic {S_DATA, S_PARITY} state_t;

  // Generator coefficients g0..g15 of prod(x + alpha^i), i = 0..15; g16 = 1 is implicit.
  localparam logic [7:0] G [16] = '{8'd59, 8'd36, 8'd50, 8'd98, 8'd229, 8'd41, 8'd65, 8'd163,
                                    8'd8, 8'd30, 8'd209, 8'd68, 8'd189, 8'd104, 8'd13, 8'd59};

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] p [16];
  logic       out_free, accept, sync_ok, fwd, last_data, last_par;
  logic [7:0] fb;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = !Reset && (state == S_DATA) && out_free;
  assign accept    = in_valid && in_ready;
  assign last_data = (cnt == 8'(N_DATA - 1));
  assign last_par  = (cnt == 8'd15);
  assign fb        = in_data ^ p[15];

`ifdef RS_ENC_SYNC_CHECK_EN
  logic sync_err_q;
  assign sync_ok  = (cnt != 8'd0) || (in_data == 8'h47) || (in_data == 8'hB8);
  assign sync_err = sync_err_q;
`else
  assign sync_ok  = 1'b1;
  assign sync_err = 1'b0;
`endif

  assign fwd = accept && sync_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      S_DATA:   if (fwd && last_data) state_nxt = S_PARITY;
      S_PARITY: if (out_free && last_par) state_nxt = S_DATA;
      default:  state_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_DATA;
      cnt        <= 8'd0;
      for (int i = 0; i < 16; i++) p[i] <= 8'h00;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_sop    <= 1'b0;
      out_parity <= 1'b0;
`ifdef RS_ENC_SYNC_CHECK_EN
      sync_err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifdef RS_ENC_SYNC_CHECK_EN
      sync_err_q <= accept && !sync_ok;
`endif
      if (out_ready) out_valid <= 1'b0;
      case (state)
        S_DATA: begin
          if (fwd) begin
            out_data   <= in_data;
            out_valid  <= 1'b1;
            out_sop    <= (cnt == 8'd0);
            out_parity <= 1'b0;
            p[0]       <= gf_mul(fb, G[0]);
            for (int i = 1; i < 16; i++) p[i] <= p[i-1] ^ gf_mul(fb, G[i]);
            cnt        <= last_data ? 8'd0 : cnt + 8'd1;
          end
        end
        S_PARITY: begin
          // The shift stalls with the output register, so no parity byte is skipped.
          if (out_free) begin
            out_data   <= p[15];
            out_valid  <= 1'b1;
            out_sop    <= 1'b0;
            out_parity <= 1'b1;
            p[0]       <= 8'h00;
            for (int i = 1; i < 16; i++) p[i] <= p[i-1];
            cnt        <= last_par ? 8'd0 : cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: scoreboard fed from an independent polynomial-division reference.
module tb_rs_encoder;
  localparam int N = 188;

  logic       Clk = 1'b0;
  logic       Reset, in_valid, in_ready, out_valid, out_ready, out_sop, out_parity, sync_err;
  logic [7:0] in_data, out_data;

  always #5 Clk = ~Clk;

  rs_encoder #(.N_DATA(N)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
    .out_parity(out_parity), .sync_err(sync_err)
  );

  int          n_asserts = 0;
  int          n_fails = 0;
  logic [9:0]  exp_q [$];
  logic [7:0]  cap [0:255];
  logic [7:0]  cap_ref [0:255];
  logic [7:0]  pkt [0:N-1];
  logic [7:0]  exp_t [0:255];
  logic [7:0]  log_t [0:255];
  logic [7:0]  gc [0:16];
  int          cap_n, cyc, first_pop, last_pop, par_seen, blocks_sent, blocks_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  task automatic build_tables();
    logic [8:0] t;
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = 8'(i);
      t = {x, 1'b0};
      if (t[8]) t = t ^ 9'h11D;
      x = t[7:0];
    end
    for (int j = 0; j < 17; j++) gc[j] = 8'h00;
    gc[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j >= 1; j--) gc[j] = gc[j-1] ^ gmul(exp_t[i], gc[j]);
      gc[0] = gmul(exp_t[i], gc[0]);
    end
  endtask

  // Long division of m(x)*x^16 by g(x); remainder is pushed highest degree first.
  task automatic push_parity();
    logic [7:0] bf [0:N+15];
    logic [7:0] c;
    for (int i = 0; i < N + 16; i++) bf[i] = (i < N) ? pkt[i] : 8'h00;
    for (int i = 0; i < N; i++) begin
      c = bf[i];
      for (int j = 1; j <= 16; j++) bf[i+j] = bf[i+j] ^ gmul(c, gc[16-j]);
    end
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, 1'b1, bf[N+k]});
  endtask

  function automatic logic [7:0] syn_or(input int flip_idx, input logic [7:0] mask);
    logic [7:0] s;
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 16; i++) begin
      s = 8'h00;
      for (int k = 0; k < N + 16; k++) s = gmul(s, exp_t[i]) ^ cap[k] ^ ((k == flip_idx) ? mask : 8'h00);
      acc = acc | s;
    end
    return acc;
  endfunction

  // One cycle: sample/check at negedge, then return just after the next rising edge.
  task automatic step(output bit acc);
    logic [9:0] e;
    @(negedge Clk);
    cyc++;
    acc = in_valid && in_ready;
    if (!Reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_byte", 32'({out_sop, out_parity, out_data}), 32'(e));
        if (cap_n < 256) cap[cap_n] = out_data;
        cap_n++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (out_parity) begin
          par_seen++;
          if (par_seen == 16) begin
            par_seen = 0;
            blocks_done++;
          end
        end
      end
    end
    if (!Reset && blocks_sent > blocks_done) chk("in_ready_during_parity", 32'(in_ready), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  task automatic run_block(input int mode, input bit chk_gap);
    int idx;
    int budget;
    bit acc;
    idx = 0;
    budget = 0;
    first_pop = -1;
    cap_n = 0;
    while ((idx < N || exp_q.size() > 0) && budget < 3000) begin
      in_valid  = (idx < N) && (mode == 0 || $urandom_range(0, 1) == 1);
      in_data   = (idx < N) ? pkt[idx] : 8'h00;
      out_ready = (mode == 0) || ((cyc / 3) % 2 == 0);
      step(acc);
      if (acc) begin
        exp_q.push_back({(idx == 0), 1'b0, pkt[idx]});
        idx++;
        if (idx == N) begin
          push_parity();
          blocks_sent++;
        end
      end
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("block_within_budget", 32'(budget < 3000), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("block_length", 32'(cap_n), 32'(N + 16));
    if (chk_gap) chk("no_gap_204", 32'(last_pop - first_pop + 1), 32'(N + 16));
  endtask

  task automatic apply_reset();
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(negedge Clk);
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    par_seen = 0;
    blocks_done = blocks_sent;
    @(negedge Clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sop", 32'(out_sop), 32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_par [0:15];
    logic [7:0] ms;
    int         diff;
    bit         acc;
    cyc = 0; par_seen = 0; blocks_sent = 0; blocks_done = 0; cap_n = 0; first_pop = -1; last_pop = 0;
    build_tables();
    exp_par = '{8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
                8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59};

    apply_reset();

    // All-zero packet at full rate.
    for (int i = 0; i < N; i++) pkt[i] = 8'h00;
    run_block(0, 1);

    // Impulse in the last data byte yields the generator coefficients.
    pkt[N-1] = 8'h01;
    run_block(0, 1);
    for (int k = 0; k < 16; k++) chk($sformatf("impulse_parity_%0d", k), 32'(cap[N+k]), 32'(exp_par[k]));

    // Sync byte plus counting pattern: zero syndromes, and a flipped byte breaks them.
    pkt[0] = 8'h47;
    for (int i = 1; i < N; i++) pkt[i] = 8'(i);
    run_block(0, 1);
    chk("syndromes_zero", 32'(syn_or(-1, 8'h00)), 32'd0);
    chk("syndromes_flip_nonzero", 32'(syn_or(5, 8'h01) != 8'h00), 32'd1);

    // Random packet: full rate, then throttled with gappy input; streams must match.
    pkt[0] = 8'hB8;
    for (int i = 1; i < N; i++) pkt[i] = 8'($urandom_range(0, 255));
    run_block(0, 1);
    for (int k = 0; k < N + 16; k++) cap_ref[k] = cap[k];
    run_block(1, 0);
    diff = 0;
    for (int k = 0; k < N + 16; k++) if (cap[k] !== cap_ref[k]) diff++;
    chk("throttled_matches_full_rate", 32'(diff), 32'd0);

    // Abort at data byte 100; the next zero packet must carry all-zero parity.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = pkt[i]; out_ready = 1'b1;
      step(acc);
      if (acc) exp_q.push_back({(i == 0), 1'b0, pkt[i]});
    end
    apply_reset();
    for (int i = 0; i < N; i++) pkt[i] = 8'h00;
    run_block(0, 1);
    ms = 8'h00;
    for (int k = 0; k < 16; k++) ms = ms | cap[N+k];
    chk("post_abort_parity_zero", 32'(ms), 32'd0);

`ifdef RS_ENC_SYNC_CHECK_EN
    in_valid = 1'b1; in_data = 8'h12; out_ready = 1'b1;
    step(acc);
    chk("bad_sync_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
    @(negedge Clk);
    chk("sync_err_pulse", 32'(sync_err), 32'd1);
    chk("bad_sync_not_forwarded", 32'(out_valid), 32'd0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("sync_err_one_cycle", 32'(sync_err), 32'd0);
    @(posedge Clk);
    #1;
    pkt[0] = 8'h47;
    for (int i = 1; i < N; i++) pkt[i] = 8'(i);
    run_block(0, 1);
    chk("sync_block_byte0", 32'(cap[0]), 32'h47);
`else
    pkt[0] = 8'h12;
    for (int i = 1; i < N; i++) pkt[i] = 8'(i);
    run_block(0, 1);
    chk("no_sync_check_byte0", 32'(cap[0]), 32'h12);
    chk("sync_err_tied_low", 32'(sync_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
